pulse_generator: RTL and testbench



---
 rtl/pulse_gen_pkg.sv | 22 ++
 rtl/pulse_gen_if.sv | 14 +
 rtl/pulse_gen_channel.sv | 80 ++++++++
 rtl/pulse_generator.sv | 37 +++
 tb/tb_pulse_generator.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared state encoding and counter sizing for the pulse generator.
// Optional behaviour is selected with the PULSE_GEN_RETRIGGER_EN macro.
package pulse_gen_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACTIVE = ST_ACTIVE,
    GAP    = ST_GAP
  } state_t;

  // Wide enough to hold the larger of the two load values (PULSE_LEN-1, GAP_LEN-1).
  function automatic int cnt_width(input int pulse_len, input int gap_len);
    int longest;
    longest = (pulse_len > gap_len) ? pulse_len : gap_len;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/pulse_gen_if.sv
// Per-channel trigger/pulse bundle between the control logic (master) and the generator (slave).
interface pulse_gen_if #(
  parameter int SIGNAL_NUM = 8
);

  logic [SIGNAL_NUM-1:0] trigger;
  logic [SIGNAL_NUM-1:0] signal_output;
  logic [SIGNAL_NUM-1:0] busy;
  logic [SIGNAL_NUM-1:0] dropped;

  modport master (output trigger, input signal_output, input busy, input dropped);
  modport slave  (input trigger, output signal_output, output busy, output dropped);

endinterface

// File: rtl/pulse_gen_channel.sv
// One channel: IDLE -> ACTIVE -> GAP -> IDLE with an active-high registered pulse.
// PULSE_GEN_RETRIGGER_EN lets a trigger during ACTIVE extend the pulse instead of dropping it.
module pulse_gen_channel
  import pulse_gen_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic pulse,
  output logic busy,
  output logic dropped
);

  localparam int CNT_W = cnt_width(PULSE_LEN, GAP_LEN);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_LEN - 1);

`ifdef PULSE_GEN_RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Outputs are updated alongside the state so they never lag or glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pulse   <= 1'b0;
      busy    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      dropped <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            state <= ACTIVE;
            cnt   <= PULSE_LOAD;
            pulse <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ACTIVE: begin
          dropped <= trigger && !RETRIGGER;
          if (RETRIGGER && trigger) begin
            cnt <= PULSE_LOAD;
          end else if (cnt == '0) begin
            state <= GAP;
            cnt   <= GAP_LOAD;
            pulse <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          dropped <= trigger;
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          pulse <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pulse_generator.sv
// Array of independent pulse channels; polarity is applied on the way out.
// Build with PULSE_GEN_RETRIGGER_EN defined to allow pulse extension on retrigger.
module pulse_generator
  import pulse_gen_pkg::*;
#(
  parameter int SIGNAL_NUM = 8,
  parameter int PULSE_LEN  = 4,
  parameter int GAP_LEN    = 2,
  parameter int POLARITY   = 0
) (
  input  logic        clk,
  input  logic        rst,
  pulse_gen_if.slave  bus
);

  localparam logic POL_BIT = 1'(POLARITY);

  logic [SIGNAL_NUM-1:0] pulse;

  for (genvar g = 0; g < SIGNAL_NUM; g++) begin : g_ch
    pulse_gen_channel #(
      .PULSE_LEN (PULSE_LEN),
      .GAP_LEN   (GAP_LEN)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .trigger (bus.trigger[g]),
      .pulse   (pulse[g]),
      .busy    (bus.busy[g]),
      .dropped (bus.dropped[g])
    );
  end

  // Inverting a flop output with a constant keeps the output effectively registered.
  assign bus.signal_output = pulse ^ {SIGNAL_NUM{POL_BIT}};

endmodule

// File: tb/tb_pulse_generator.sv
// Scoreboard bench: one active-high and one active-low generator driven side by side.
module tb_pulse_generator;

  typedef struct packed {
    logic [7:0] out;
    logic [7:0] busy;
    logic [7:0] drop;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  logic [7:0] s1, s2;
  int         edge_cnt [8];
  logic       edge_clear = 1'b0;

  pulse_gen_if #(.SIGNAL_NUM(8)) if0 ();
  pulse_gen_if #(.SIGNAL_NUM(8)) if1 ();

  pulse_generator #(.SIGNAL_NUM(8), .PULSE_LEN(4), .GAP_LEN(2), .POLARITY(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  pulse_generator #(.SIGNAL_NUM(8), .PULSE_LEN(4), .GAP_LEN(2), .POLARITY(1)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  always #5 clk = ~clk;

  // Two-flop receiver on the active-low outputs, counting falling (activating) edges.
  always @(posedge clk) begin
    s1 <= if1.signal_output;
    s2 <= s1;
    for (int c = 0; c < 8; c++) begin
      if (edge_clear) edge_cnt[c] <= 0;
      else if (s2[c] && !s1[c]) edge_cnt[c] <= edge_cnt[c] + 1;
    end
  end

  task automatic test_reset();
    exp_t e;
    logic [23:0] got;
    for (int i = 0; i < 4; i++) begin
      rst = (i < 3);
      if0.trigger = (i < 3) ? 8'hFF : 8'h00;
      if1.trigger = (i < 3) ? 8'hFF : 8'h00;
      e.out = 8'h00; e.busy = 8'h00; e.drop = 8'h00;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      got = {if0.signal_output, if0.busy, if0.dropped};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL reset step %0d: out/busy/dropped got %h required %h", i, got, e);
      end
      vectors++;
      if (if1.signal_output !== 8'hFF) begin
        miscompares++;
        $display("[TB] FAIL reset_idle_high step %0d: got %h required ff", i, if1.signal_output);
      end
    end
  endtask

  task automatic test_single();
    exp_t e;
    logic [23:0] got;
    for (int i = 0; i < 8; i++) begin
      if0.trigger = (i == 0) ? 8'h01 : 8'h00;
      e.out  = (i < 4) ? 8'h01 : 8'h00;
      e.busy = (i < 6) ? 8'h01 : 8'h00;
      e.drop = 8'h00;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      got = {if0.signal_output, if0.busy, if0.dropped};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL single step %0d: out/busy/dropped got %h required %h", i, got, e);
      end
    end
    if0.trigger = 8'h00;
  endtask

  task automatic test_gap_trigger();
    exp_t e;
    logic [23:0] got;
    for (int i = 0; i < 14; i++) begin
      if0.trigger = (i == 0 || i == 5 || i == 7) ? 8'h04 : 8'h00;
      e.out  = (i < 4 || (i >= 7 && i < 11)) ? 8'h04 : 8'h00;
      e.busy = (i < 6 || (i >= 7 && i < 13)) ? 8'h04 : 8'h00;
      e.drop = (i == 5) ? 8'h04 : 8'h00;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      got = {if0.signal_output, if0.busy, if0.dropped};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL gap_trigger step %0d: out/busy/dropped got %h required %h", i, got, e);
      end
    end
    if0.trigger = 8'h00;
  endtask

  task automatic test_active_trigger();
    exp_t e;
    logic [23:0] got;
    for (int i = 0; i < 10; i++) begin
      if0.trigger = (i == 0 || i == 2) ? 8'h02 : 8'h00;
`ifdef PULSE_GEN_RETRIGGER_EN
      e.out  = (i < 6) ? 8'h02 : 8'h00;
      e.busy = (i < 8) ? 8'h02 : 8'h00;
      e.drop = 8'h00;
`else
      e.out  = (i < 4) ? 8'h02 : 8'h00;
      e.busy = (i < 6) ? 8'h02 : 8'h00;
      e.drop = (i == 2) ? 8'h02 : 8'h00;
`endif
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      got = {if0.signal_output, if0.busy, if0.dropped};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL active_trigger step %0d: out/busy/dropped got %h required %h", i, got, e);
      end
    end
    if0.trigger = 8'h00;
  endtask

  task automatic test_reset_mid_pulse();
    exp_t e;
    logic [23:0] got;
    for (int i = 0; i < 12; i++) begin
      rst = (i == 2);
      if0.trigger = (i == 0 || i == 4) ? 8'h08 : 8'h00;
      e.out  = (i < 2 || (i >= 4 && i < 8)) ? 8'h08 : 8'h00;
      e.busy = (i < 2 || (i >= 4 && i < 10)) ? 8'h08 : 8'h00;
      e.drop = 8'h00;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      got = {if0.signal_output, if0.busy, if0.dropped};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_pulse step %0d: out/busy/dropped got %h required %h", i, got, e);
      end
    end
    rst = 1'b0;
    if0.trigger = 8'h00;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [23:0] got;
    for (int i = 0; i < 8; i++) begin
      if0.trigger = (i == 0) ? 8'hFF : 8'h00;
      e.out  = (i < 4) ? 8'hFF : 8'h00;
      e.busy = (i < 6) ? 8'hFF : 8'h00;
      e.drop = 8'h00;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      got = {if0.signal_output, if0.busy, if0.dropped};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL all_channels step %0d: out/busy/dropped got %h required %h", i, got, e);
      end
    end
    if0.trigger = 8'h00;
  endtask

  task automatic test_polarity();
    exp_t e;
    logic [23:0] got;
    edge_clear = 1'b1;
    @(negedge clk);
    edge_clear = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if1.trigger = (i == 0) ? 8'hFF : 8'h00;
      e.out  = (i < 4) ? 8'h00 : 8'hFF;
      e.busy = (i < 6) ? 8'hFF : 8'h00;
      e.drop = 8'h00;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      got = {if1.signal_output, if1.busy, if1.dropped};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL polarity step %0d: out/busy/dropped got %h required %h", i, got, e);
      end
    end
    if1.trigger = 8'h00;
    for (int c = 0; c < 8; c++) begin
      vectors++;
      if (edge_cnt[c] !== 1) begin
        miscompares++;
        $display("[TB] FAIL edge_count ch%0d: got %0d required 1", c, edge_cnt[c]);
      end
    end
  endtask

  initial begin
    if0.trigger = 8'h00;
    if1.trigger = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_gap_trigger();
    test_active_trigger();
    test_reset_mid_pulse();
    test_back_to_back();
    test_polarity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
